sdram_bram_responder: RTL and testbench

- Responder end of the SDRAM controller request/acknowledge interface.
- Presents the same ports and handshake the board wrappers drive into the SDRAM controller: level requests, one-cycle acks, byte enables, word address, init-done flag.
- Backs that interface with on-chip block RAM, so boards without SDRAM, and simulation benches, can run the kernel unchanged.
- Emulates controller timing: init delay, read/write latency and, optionally, refresh stalls.

---
 rtl/sdram_bram_responder_pkg.sv | 17 +
 rtl/sdram_bram_responder_bram_be_sp.sv | 19 +
 rtl/sdram_bram_responder.sv | 125 ++++++++++++
 tb/tb_sdram_bram_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sdram_bram_responder_pkg.sv
// sdram_bram_responder_pkg: shared widths, default timing and FSM state codes for the BRAM-backed SDRAM responder.
package sdram_bram_responder_pkg;
  localparam int ADDR_BITS = 22;
  localparam int DATA_BITS = 16;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_INIT_CYCLES = 200;
  localparam int DEF_WR_LAT = 2;
  localparam int DEF_RD_LAT = 3;
  localparam int DEF_REF_PERIOD = 780;
  localparam int DEF_REF_CYCLES = 8;
  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  localparam logic [2:0] ST_REFRESH = 3'd5;
endpackage

// File: rtl/sdram_bram_responder_bram_be_sp.sv
// bram_be_sp: single-port block RAM with per-byte write enables and a registered read port.
module bram_be_sp
  import sdram_bram_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic [1:0]           we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);
  logic [DATA_BITS-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0] <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/sdram_bram_responder.sv
// sdram_bram_responder: SDRAM-controller-compatible req/ack responder backed by block RAM with emulated timing.
// Define REFRESH_STALL_EN to add periodic refresh stalls that delay acceptance of new requests.
module sdram_bram_responder
  import sdram_bram_responder_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int WR_LAT      = DEF_WR_LAT,
  parameter int RD_LAT      = DEF_RD_LAT,
  parameter int REF_PERIOD  = DEF_REF_PERIOD,
  parameter int REF_CYCLES  = DEF_REF_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sdram_wr_req,
  input  logic                 sdram_rd_req,
  output logic                 sdram_wr_ack,
  output logic                 sdram_rd_ack,
  input  logic [1:0]           sdram_byteenable,
  input  logic [ADDR_BITS-1:0] sys_wraddr,
  input  logic [ADDR_BITS-1:0] sys_rdaddr,
  input  logic [DATA_BITS-1:0] sys_data_in,
  output logic [DATA_BITS-1:0] sys_data_out,
  output logic                 sdram_init_done
);
  logic [2:0]           state;
  logic [31:0]          cnt;
  logic                 op_wr;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic                 refresh_due;
  logic                 accept_wr;
  logic [1:0]           ram_we;
  logic [ADDR_W-1:0]    ram_addr;
  logic [DATA_BITS-1:0] ram_q;
  logic                 unused_bits;
  // The write lands in RAM on the acceptance edge, so data/lanes need no holding register.
  assign accept_wr = state == ST_IDLE && !refresh_due && sdram_wr_req;
  assign ram_we = accept_wr ? sdram_byteenable : 2'b00;
  assign ram_addr = accept_wr ? sys_wraddr[ADDR_W-1:0] : rd_addr_q;
  bram_be_sp #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (sys_data_in),
    .rdata (ram_q)
  );
`ifdef REFRESH_STALL_EN
  logic [31:0] ref_cnt;
  logic        ref_pending;
  logic        ref_expire;
  assign ref_expire = sdram_init_done && ref_cnt == 32'(REF_PERIOD - 1);
  assign refresh_due = ref_pending || ref_expire;
  assign unused_bits = ^{sys_wraddr, sys_rdaddr};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      ref_pending <= 1'b0;
    end else if (sdram_init_done) begin
      ref_cnt <= ref_expire ? '0 : ref_cnt + 32'd1;
      ref_pending <= state == ST_IDLE ? 1'b0 : ref_pending || ref_expire;
    end
  end
`else
  assign refresh_due = 1'b0;
  assign unused_bits = ^{sys_wraddr, sys_rdaddr, 32'(REF_PERIOD), 32'(REF_CYCLES)};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt <= '0;
      op_wr <= 1'b0;
      rd_addr_q <= '0;
      sdram_wr_ack <= 1'b0;
      sdram_rd_ack <= 1'b0;
      sys_data_out <= '0;
      sdram_init_done <= 1'b0;
    end else begin
      sdram_wr_ack <= 1'b0;
      sdram_rd_ack <= 1'b0;
      case (state)
        ST_INIT: begin
          if (cnt == 32'(INIT_CYCLES - 1)) begin
            sdram_init_done <= 1'b1;
            state <= ST_IDLE;
            cnt <= '0;
          end else cnt <= cnt + 32'd1;
        end
        ST_IDLE: begin
          // The deciding IDLE clock counts as the first refresh busy clock.
          cnt <= refresh_due ? 32'd1 : 32'd0;
          if (refresh_due) state <= ST_REFRESH;
          else if (sdram_wr_req) begin
            state <= ST_WRITE;
            op_wr <= 1'b1;
          end else if (sdram_rd_req) begin
            state <= ST_READ;
            op_wr <= 1'b0;
            rd_addr_q <= sys_rdaddr[ADDR_W-1:0];
          end
        end
        ST_WRITE: begin
          if (cnt == 32'(WR_LAT - 1)) begin
            sdram_wr_ack <= 1'b1;
            state <= ST_RELEASE;
          end else cnt <= cnt + 32'd1;
        end
        ST_READ: begin
          if (cnt == 32'(RD_LAT - 1)) begin
            sdram_rd_ack <= 1'b1;
            sys_data_out <= ram_q;
            state <= ST_RELEASE;
          end else cnt <= cnt + 32'd1;
        end
        ST_RELEASE: if (!(op_wr ? sdram_wr_req : sdram_rd_req)) state <= ST_IDLE;
`ifdef REFRESH_STALL_EN
        ST_REFRESH: begin
          if (cnt >= 32'(REF_CYCLES - 1)) state <= ST_IDLE;
          else cnt <= cnt + 32'd1;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_bram_responder.sv
// tb_sdram_bram_responder: randomized req/ack traffic checked against a word-array memory model and timing rules.
module tb_sdram_bram_responder;
  localparam int INIT = 200;
  localparam int WLAT = 2;
  localparam int RLAT = 3;
  localparam int RPER = 50;
  localparam int RCYC = 8;
`ifdef REFRESH_STALL_EN
  localparam int REF_ACK = 250 + RCYC + RLAT;
`else
  localparam int REF_ACK = 250 + RLAT;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_req = 1'b0;
  logic rd_req = 1'b0;
  logic [1:0] be = 2'b00;
  logic [21:0] wa = '0;
  logic [21:0] ra = '0;
  logic [15:0] din = '0;
  logic wr_ack, rd_ack, init_done;
  logic [15:0] dout;
  int checks = 0;
  int failures = 0;
  logic [15:0] model [int];
  int pool [16];
  always #5 clk = ~clk;
  sdram_bram_responder #(.REF_PERIOD(RPER), .REF_CYCLES(RCYC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sdram_wr_req     (wr_req),
    .sdram_rd_req     (rd_req),
    .sdram_wr_ack     (wr_ack),
    .sdram_rd_ack     (rd_ack),
    .sdram_byteenable (be),
    .sys_wraddr       (wa),
    .sys_rdaddr       (ra),
    .sys_data_in      (din),
    .sys_data_out     (dout),
    .sdram_init_done  (init_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic quiet(input string tag);
    check({tag, "_wack"}, wr_ack, 1'b0);
    check({tag, "_rack"}, rd_ack, 1'b0);
  endtask
  task automatic txn(input bit wr, input logic [21:0] a, input logic [15:0] d, input logic [1:0] b,
                     input int hold, output logic [15:0] rdata);
    int n = 0;
    bit got = 1'b0;
    int idx = int'(a[13:0]);
    rdata = '0;
    if (wr) begin
      wr_req = 1'b1; wa = a; din = d; be = b;
    end else begin
      rd_req = 1'b1; ra = a;
    end
    while (!got && n < 40) begin
      step();
      n++;
`ifndef REFRESH_STALL_EN
      if (n == 1) begin
        wa = 22'($urandom); ra = 22'($urandom); din = 16'($urandom); be = 2'($urandom);
      end
`endif
      got = wr ? wr_ack : rd_ack;
      check("other_ack", wr ? rd_ack : wr_ack, 1'b0);
    end
    check(wr ? "wr_ack_seen" : "rd_ack_seen", got, 1'b1);
`ifndef REFRESH_STALL_EN
    check(wr ? "wr_latency" : "rd_latency", n, 1 + (wr ? WLAT : RLAT));
`endif
    if (wr) begin
      if (!model.exists(idx)) model[idx] = '0;
      if (b[0]) model[idx][7:0] = d[7:0];
      if (b[1]) model[idx][15:8] = d[15:8];
    end else begin
      rdata = dout;
      if (model.exists(idx)) check("rd_data", dout, model[idx]);
    end
    repeat (hold) begin
      step();
      quiet("hold");
    end
    if (wr) wr_req = 1'b0;
    else rd_req = 1'b0;
    step();
    quiet("drop");
    if (!wr) check("dout_hold", dout, rdata);
  endtask
  initial begin
    logic [15:0] r;
    int n, m;
    rd_req = 1'b1;
    ra = 22'h000777;
    step();
    check("rst_init_done", init_done, 1'b0);
    check("rst_dout", dout, 16'h0);
    quiet("rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 265; i++) begin
      step();
      check("init_done", init_done, i >= INIT);
      check("init_rack", rd_ack, i == INIT + 1 + RLAT || i == REF_ACK);
      check("init_wack", wr_ack, 1'b0);
      if (i == INIT + 1 + RLAT || i == REF_ACK) rd_req = 1'b0;
      if (i == 249) rd_req = 1'b1;
    end
    txn(1'b1, 22'h000123, 16'hA5C3, 2'b11, 0, r);
    txn(1'b1, 22'h000123, 16'h7700, 2'b10, 0, r);
    txn(1'b0, 22'h000123, 16'h0, 2'b00, 0, r);
    check("byte_merge", r, 16'h77C3);
    txn(1'b1, 22'h000055, 16'hCAFE, 2'b11, 4, r);
    txn(1'b0, 22'h000055, 16'h0, 2'b00, 0, r);
    check("held_rd", r, 16'hCAFE);
    wa = 22'h000200; ra = 22'h000200; din = 16'h1234; be = 2'b11;
    wr_req = 1'b1; rd_req = 1'b1;
    n = 0;
    while (wr_ack !== 1'b1 && n < 40) begin
      step(); n++;
      check("sim_rack_early", rd_ack, 1'b0);
    end
    check("sim_wack_seen", wr_ack, 1'b1);
`ifndef REFRESH_STALL_EN
    check("sim_wr_latency", n, 1 + WLAT);
`endif
    model[32'h200] = 16'h1234;
    wr_req = 1'b0;
    m = 0;
    while (rd_ack !== 1'b1 && m < 40) begin
      step(); m++;
      check("sim_wack_extra", wr_ack, 1'b0);
    end
    check("sim_rack_seen", rd_ack, 1'b1);
`ifndef REFRESH_STALL_EN
    check("sim_rd_latency", m, 2 + RLAT);
`endif
    check("sim_rd_data", dout, 16'h1234);
    rd_req = 1'b0;
    step();
    quiet("sim_drop");
    for (int i = 0; i < 16; i++) begin
      pool[i] = i * 37;
      txn(1'b1, 22'(pool[i]), 16'($urandom), 2'b11, 0, r);
    end
    for (int i = 0; i < 60; i++) begin
      logic [21:0] a;
      a = 22'(($urandom_range(0, 255) << 14) | pool[$urandom_range(0, 15)]);
      txn(1'($urandom), a, 16'($urandom), 2'($urandom), $urandom_range(0, 3), r);
      repeat ($urandom_range(0, 2)) begin
        step();
        quiet("gap");
      end
    end
    txn(1'b1, 22'h204000, 16'hBEEF, 2'b11, 0, r);
    txn(1'b0, 22'h000000, 16'h0, 2'b00, 0, r);
    check("alias_rd", r, 16'hBEEF);
    ra = 22'h000000;
    rd_req = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_init_done", init_done, 1'b0);
    check("midrst_dout", dout, 16'h0);
    quiet("midrst");
    rd_req = 1'b0;
    repeat (5) begin
      step();
      quiet("inrst");
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (init_done !== 1'b1 && n < 400) begin
      step(); n++;
      quiet("reinit");
    end
    check("reinit_cycles", n, INIT);
    txn(1'b0, 22'h000000, 16'h0, 2'b00, 0, r);
    check("reinit_rd", r, 16'hBEEF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
